register_file: RTL and testbench

// - RISC-V integer register file: 32 x 32-bit general-purpose registers, x0 hardwired to zero.
// - Two asynchronous (combinational) read ports and one synchronous write port.
// - Sits in the decode/writeback path of the single-clock CPU core.
// - Writeback drives the write port; decode drives the two source-operand read ports.
//

---
 rtl/register_file_pkg.sv | 22 ++
 rtl/register_file_read_port.sv | 35 +++
 rtl/register_file.sv | 79 +++++++
 tb/tb_register_file.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// -----------------------------------------------------------------------------
// register_file_pkg
//
// Shared constants for the integer register file and the core that uses it.
//   XLEN        architectural register width
//   REG_COUNT   number of architectural integer registers (x0..x31)
//   REG_ADDR_W  register index width
//   REG_ZERO    index of the hardwired-zero register x0
//   FIRST_REG   lowest index that is backed by storage
// -----------------------------------------------------------------------------
package register_file_pkg;

  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = $clog2(REG_COUNT);

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 has no storage, so the physical array starts one index above it.
  localparam int FIRST_REG = int'(REG_ZERO) + 1;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
//
// One combinational read port of the register file: a 2**ADDR_WIDTH : 1 mux
// over the stored registers, returning zero for x0 (which has no storage).
//
// Ports
//   regs       in   stored registers x1..x(2**ADDR_WIDTH-1)
//   read_addr  in   register index to read
//   read_data  out  selected register value, zero for x0
// -----------------------------------------------------------------------------
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic [DATA_WIDTH-1:0] regs [FIRST_REG:2**ADDR_WIDTH-1],
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  // NOTE: the default assignment before the loop keeps this purely
  // combinational; without it, any unmatched index would infer a latch.
  // Index 0 never matches an entry, so it falls through to zero.
  always_comb begin
    read_data = '0;
    for (int i = FIRST_REG; i < 2**ADDR_WIDTH; i++) begin
      if (read_addr == ADDR_WIDTH'(i)) begin
        read_data = regs[i];
      end
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// RISC-V integer register file: 2**ADDR_WIDTH x DATA_WIDTH registers with x0
// hardwired to zero, two combinational read ports and one synchronous write
// port. There is no write-to-read bypass: a read of the register being written
// returns the old value until the clock edge; forwarding belongs to the
// pipeline.
//
// Ports
//   clk              in   system clock, writes on the rising edge
//   rst              in   asynchronous reset, active low; clears every register
//   reg_write_en     in   write enable
//   reg_write_dest   in   destination register index (writes to x0 are dropped)
//   reg_write_data   in   value to write
//   reg_read_addr_1  in   read port 1 index
//   reg_read_data_1  out  read port 1 data
//   reg_read_addr_2  in   read port 2 index
//   reg_read_data_2  out  read port 2 data
// -----------------------------------------------------------------------------
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_write_dest,
  input  logic [DATA_WIDTH-1:0] reg_write_data,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
  output logic [DATA_WIDTH-1:0] reg_read_data_1,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
  output logic [DATA_WIDTH-1:0] reg_read_data_2
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  // Storage for x1..x(DEPTH-1); x0 is produced by the read mux.
  logic [DATA_WIDTH-1:0] regs [FIRST_REG:DEPTH-1];

  // NOTE: the whole array sits in reset flops rather than a RAM macro because
  // reset must clear every register immediately, without a clock. Non-blocking
  // assignments keep reads in the same edge seeing the pre-edge values.
  // The index compare excludes x0, so a write to it is simply discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = FIRST_REG; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = FIRST_REG; i < DEPTH; i++) begin
        if (reg_write_en && (reg_write_dest == ADDR_WIDTH'(i))) begin
          regs[i] <= reg_write_data;
        end
      end
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_1 (
    .regs      (regs),
    .read_addr (reg_read_addr_1),
    .read_data (reg_read_data_1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_2 (
    .regs      (regs),
    .read_addr (reg_read_addr_2),
    .read_data (reg_read_data_2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file: reset behaviour, a table of directed
// write/read vectors, hand-written multi-cycle sequences (same-cycle
// read/write, asynchronous reset pulse, release-then-write), and randomized
// traffic against an array model of the architectural registers.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREGS = 32;

  logic          clk;
  logic          rst;
  logic          reg_write_en;
  logic [AW-1:0] reg_write_dest;
  logic [DW-1:0] reg_write_data;
  logic [AW-1:0] reg_read_addr_1;
  logic [DW-1:0] reg_read_data_1;
  logic [AW-1:0] reg_read_addr_2;
  logic [DW-1:0] reg_read_data_2;

  int checks = 0;
  int errors = 0;

  // Architectural view: model[0] is never written and stays zero.
  logic [DW-1:0] model [NREGS];

  typedef struct {
    logic          en;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
  } vec_t;

  vec_t tbl [6];

  register_file dut (
    .clk             (clk),
    .rst             (rst),
    .reg_write_en    (reg_write_en),
    .reg_write_dest  (reg_write_dest),
    .reg_write_data  (reg_write_data),
    .reg_read_addr_1 (reg_read_addr_1),
    .reg_read_data_1 (reg_read_data_1),
    .reg_read_addr_2 (reg_read_addr_2),
    .reg_read_data_2 (reg_read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] actual,
                       input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
  endtask

  task automatic model_write(input logic en, input logic [AW-1:0] dest,
                             input logic [DW-1:0] data);
    if (en && dest != 0) model[dest] = data;
  endtask

  // Rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < NREGS; i++) begin
      reg_read_addr_1 = AW'(i);
      reg_read_addr_2 = AW'(NREGS - 1 - i);
      #1;
      check({name, "_p1"}, reg_read_data_1, 32'h0);
      check({name, "_p2"}, reg_read_data_2, 32'h0);
    end
  endtask

  initial begin
    // Directed table: write inputs and read addresses applied together, read
    // results compared after the edge.
    tbl[0] = '{1'b1, 5'd1,  32'hAABBCCDD, 5'd1,  5'd0,  32'hAABBCCDD, 32'h00000000};
    tbl[1] = '{1'b1, 5'd2,  32'h11223344, 5'd1,  5'd2,  32'hAABBCCDD, 32'h11223344};
    tbl[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd2,  32'h00000000, 32'h11223344};
    tbl[3] = '{1'b0, 5'd1,  32'hDEADBEEF, 5'd1,  5'd1,  32'hAABBCCDD, 32'hAABBCCDD};
    tbl[4] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd30, 32'h00000001, 32'h00000000};
    tbl[5] = '{1'b1, 5'd5,  32'h00000005, 5'd5,  5'd31, 32'h00000005, 32'h00000001};

    // Reset held, with a write attempted that must be ignored.
    rst             = 1'b0;
    reg_write_en    = 1'b1;
    reg_write_dest  = 5'd3;
    reg_write_data  = 32'hDEADBEEF;
    reg_read_addr_1 = '0;
    reg_read_addr_2 = '0;
    model_reset();
    tick();
    tick();
    check_all_zero("reset_held");

    rst          = 1'b1;
    reg_write_en = 1'b0;
    check_all_zero("reset_released");

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      reg_write_en    = tbl[i].en;
      reg_write_dest  = tbl[i].dest;
      reg_write_data  = tbl[i].data;
      reg_read_addr_1 = tbl[i].a1;
      reg_read_addr_2 = tbl[i].a2;
      tick();
      model_write(tbl[i].en, tbl[i].dest, tbl[i].data);
      check($sformatf("vec%0d_p1", i), reg_read_data_1, tbl[i].exp1);
      check($sformatf("vec%0d_p2", i), reg_read_data_2, tbl[i].exp2);
    end

    // Same-cycle write and read of x5: old value before the edge, new after.
    reg_read_addr_1 = 5'd5;
    reg_read_addr_2 = 5'd5;
    reg_write_en    = 1'b1;
    reg_write_dest  = 5'd5;
    reg_write_data  = 32'h12345678;
    #1;
    check("rw_same_before", reg_read_data_1, 32'h00000005);
    tick();
    model_write(1'b1, 5'd5, 32'h12345678);
    check("rw_same_after_p1", reg_read_data_1, 32'h12345678);
    check("rw_same_after_p2", reg_read_data_2, 32'h12345678);

    // Load x31, then pulse reset between edges: x31 clears with no clock.
    reg_write_dest = 5'd31;
    reg_write_data = 32'hCAFEF00D;
    reg_read_addr_1 = 5'd31;
    reg_read_addr_2 = 5'd1;
    tick();
    model_write(1'b1, 5'd31, 32'hCAFEF00D);
    check("x31_loaded", reg_read_data_1, 32'hCAFEF00D);
    #2;
    rst = 1'b0;
    #1;
    check("x31_async_clear", reg_read_data_1, 32'h0);
    check("x1_async_clear", reg_read_data_2, 32'h0);
    model_reset();

    // A write presented across an edge while reset is held is lost.
    reg_write_dest = 5'd9;
    reg_write_data = 32'h99999999;
    reg_read_addr_1 = 5'd9;
    tick();
    check("write_in_reset_lost", reg_read_data_1, 32'h0);

    // Release mid-cycle: the very next edge writes.
    #2;
    rst            = 1'b1;
    reg_write_dest = 5'd7;
    reg_write_data = 32'h77777777;
    reg_read_addr_1 = 5'd7;
    reg_read_addr_2 = 5'd9;
    #1;
    check("pre_release_write", reg_read_data_1, 32'h0);
    tick();
    model_write(1'b1, 5'd7, 32'h77777777);
    check("release_first_write", reg_read_data_1, 32'h77777777);
    check("release_x9_still_zero", reg_read_data_2, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reg_write_en    = ($urandom_range(3) != 0);
      reg_write_dest  = AW'($urandom_range(NREGS - 1));
      reg_write_data  = $urandom;
      reg_read_addr_1 = AW'($urandom_range(NREGS - 1));
      reg_read_addr_2 = AW'($urandom_range(NREGS - 1));
      if ($urandom_range(3) == 0) reg_read_addr_1 = reg_write_dest;
      #1;
      check($sformatf("rand%0d_pre_p1", n), reg_read_data_1, model[reg_read_addr_1]);
      check($sformatf("rand%0d_pre_p2", n), reg_read_data_2, model[reg_read_addr_2]);
      tick();
      model_write(reg_write_en, reg_write_dest, reg_write_data);
      check($sformatf("rand%0d_post_p1", n), reg_read_data_1, model[reg_read_addr_1]);
      check($sformatf("rand%0d_post_p2", n), reg_read_data_2, model[reg_read_addr_2]);
    end

    // Final sweep of every register on both ports.
    reg_write_en = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      reg_read_addr_1 = AW'(i);
      reg_read_addr_2 = AW'(NREGS - 1 - i);
      #1;
      check($sformatf("sweep_x%0d", i), reg_read_data_1, model[i]);
      check($sformatf("sweep_x%0d", NREGS - 1 - i), reg_read_data_2, model[NREGS - 1 - i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_register_file
